// File: rtl/bank_write_controller.sv
// bank_write_controller: debounced push-button writer for four 8-bit banks.
// The raw button is synchronized, debounced by a small FSM, and each accepted
// press writes sw_data into the bank chosen by sel exactly once. The selected
// (or scanned) bank is shown on led through a register.
//
// Optional build macro AUTO_SCAN_EN: when defined, the displayed bank rotates
// A->B->C->D every SCAN_CYCLES cycles instead of following sel.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for the synchronized button to go high
// PRESS   | button high, counting stable cycles before accepting the press
// WRITE   | single cycle: bank[sel] <= sw_data, write_strobe asserted
// RELEASE | waiting for the button to stay low long enough to re-arm
module bank_write_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SCAN_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw_data,
    input  logic [1:0] sel,
    input  logic       btn,
    output logic [7:0] led,
    output logic [1:0] bank_idx,
    output logic       write_strobe,
    output logic       busy
);

    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sync1_q, sync2_q;
    logic        btn_s;
    logic [7:0]  bank_q [4];
    logic [7:0]  led_q;
    logic [1:0]  idx_q;

    // Out-of-range parameters are rejected at elaboration time.
    generate
        if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
            SCAN_CYCLES < 2 || SCAN_CYCLES > 65535) begin : g_bad_param
            $error("bank_write_controller: DEBOUNCE_CYCLES/SCAN_CYCLES out of range 2..65535");
        end
    endgenerate

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = sync2_q;

    // FSM state and stability counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Debounce next-state logic; a held button parks in RELEASE so it can
    // never produce a second write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end
            end
            PRESS: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WRITE: begin
                state_d = RELEASE;
                cnt_d   = '0;
            end
            RELEASE: begin
                if (btn_s) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bank storage: sel and sw_data are only looked at on the edge leaving WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= 8'h00;
            end
        end else if (state_q == WRITE) begin
            bank_q[sel] <= sw_data;
        end
    end

`ifdef AUTO_SCAN_EN
    logic [15:0] scan_q;
    localparam logic [15:0] SCAN_LAST = 16'(SCAN_CYCLES - 1);

    // Free-running scan: dwell SCAN_CYCLES on each bank, then advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_q <= '0;
            idx_q  <= 2'd0;
        end else if (scan_q == SCAN_LAST) begin
            scan_q <= '0;
            idx_q  <= idx_q + 2'd1;
        end else begin
            scan_q <= scan_q + 16'd1;
        end
    end
`else
    // Displayed bank follows sel with one cycle of latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= 2'd0;
        end else begin
            idx_q <= sel;
        end
    end
`endif

    // Registered display; a bank written this cycle appears on the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= 8'h00;
        end else begin
            led_q <= bank_q[idx_q];
        end
    end

    assign led          = led_q;
    assign bank_idx     = idx_q;
    assign write_strobe = (state_q == WRITE);
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_bank_write_controller.sv
// Self-checking bench for bank_write_controller (DEBOUNCE_CYCLES=4, SCAN_CYCLES=8).
// The reference model is an array of four bank values plus the timing rules
// for a debounced press, expressed in edge counts.
module tb_bank_write_controller;

    localparam int D = 4;
    localparam int S = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sw_data = 8'h00;
    logic [1:0] sel = 2'd0;
    logic       btn = 1'b0;
    logic [7:0] led;
    logic [1:0] bank_idx;
    logic       write_strobe;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;
    logic [7:0] mdl [4];

    bank_write_controller #(.DEBOUNCE_CYCLES(D), .SCAN_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .sw_data(sw_data), .sel(sel), .btn(btn),
        .led(led), .bank_idx(bank_idx), .write_strobe(write_strobe), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (write_strobe === 1'b1) strobe_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_bank(input logic [1:0] b, output logic [7:0] v);
        sel = b;
        tick();
        tick();
        v = led;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle_timeout busy=%b expected=0", tag, busy);
        end
    endtask

    task automatic press(input logic [1:0] s, input logic [7:0] d);
        wait_idle("press");
        sel = s;
        sw_data = d;
        btn = 1'b1;
        repeat (20) tick();
        btn = 1'b0;
        repeat (12) tick();
        mdl[s] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (led !== 8'h00) begin fails++; $display("FAIL reset_led got=%h expected=00", led); end
        tests++;
        if (bank_idx !== 2'd0) begin fails++; $display("FAIL reset_bank_idx got=%0d expected=0", bank_idx); end
        tests++;
        if (write_strobe !== 1'b0) begin fails++; $display("FAIL reset_strobe got=%b expected=0", write_strobe); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b expected=0", busy); end
        for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_initial_banks();
        logic [7:0] v;
        for (int b = 0; b < 4; b++) begin
            read_bank(2'(b), v);
            tests++;
            if (v !== 8'h00) begin fails++; $display("FAIL init_bank%0d got=%h expected=00", b, v); end
        end
    endtask

    task automatic test_bank_idx_latency();
        sel = 2'd0;
        tick();
        tick();
        sel = 2'd3;
        #1;
        tests++;
        if (bank_idx !== 2'd0) begin fails++; $display("FAIL idx_before_edge got=%0d expected=0", bank_idx); end
        tick();
        tests++;
        if (bank_idx !== 2'd3) begin fails++; $display("FAIL idx_after_edge got=%0d expected=3", bank_idx); end
    endtask

    task automatic test_clean_press();
        int s0;
        logic [7:0] v;
        wait_idle("clean");
        sel = 2'd2;
        sw_data = 8'h5A;
        tick();
        tick();
        s0 = strobe_cnt;
        btn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == D + 2) begin
                tests++;
                if (write_strobe !== 1'b0) begin fails++; $display("FAIL clean_early_strobe edge=%0d got=%b expected=0", e, write_strobe); end
            end
            if (e == D + 3) begin
                tests++;
                if (write_strobe !== 1'b1) begin fails++; $display("FAIL clean_strobe edge=%0d got=%b expected=1", e, write_strobe); end
                tests++;
                if (busy !== 1'b1) begin fails++; $display("FAIL clean_busy got=%b expected=1", busy); end
            end
            if (e == D + 4) begin
                tests++;
                if (led !== mdl[2]) begin fails++; $display("FAIL clean_no_bypass got=%h expected=%h", led, mdl[2]); end
            end
            if (e == D + 5) begin
                tests++;
                if (led !== 8'h5A) begin fails++; $display("FAIL clean_led got=%h expected=5a", led); end
            end
        end
        btn = 1'b0;
        repeat (12) tick();
        mdl[2] = 8'h5A;
        tests++;
        if (strobe_cnt - s0 !== 1) begin fails++; $display("FAIL clean_strobe_count got=%0d expected=1", strobe_cnt - s0); end
        read_bank(2'd2, v);
        tests++;
        if (v !== 8'h5A) begin fails++; $display("FAIL clean_bankC got=%h expected=5a", v); end
    endtask

    task automatic test_glitch();
        int s0;
        logic [7:0] v;
        wait_idle("glitch");
        sel = 2'd1;
        sw_data = 8'hFF;
        s0 = strobe_cnt;
        btn = 1'b1;
        tick();
        tick();
        btn = 1'b0;
        tick();
        tick();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL glitch_in_press got=%b expected=1", busy); end
        tick();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL glitch_back_idle got=%b expected=0", busy); end
        repeat (5) tick();
        tests++;
        if (strobe_cnt - s0 !== 0) begin fails++; $display("FAIL glitch_strobe_count got=%0d expected=0", strobe_cnt - s0); end
        for (int b = 0; b < 4; b++) begin
            read_bank(2'(b), v);
            tests++;
            if (v !== mdl[b]) begin fails++; $display("FAIL glitch_bank%0d got=%h expected=%h", b, v, mdl[b]); end
        end
    endtask

    task automatic test_held_bounce();
        int s0;
        logic [7:0] v;
        wait_idle("held");
        sel = 2'd0;
        sw_data = 8'hA7;
        s0 = strobe_cnt;
        for (int e = 1; e <= 50; e++) begin
            btn = (e != 30);
            tick();
            if (e == 40) begin
                tests++;
                if (busy !== 1'b1) begin fails++; $display("FAIL held_busy got=%b expected=1", busy); end
            end
        end
        btn = 1'b0;
        for (int e = 51; e <= 60; e++) begin
            tick();
            if (e == 55) begin
                tests++;
                if (busy !== 1'b1) begin fails++; $display("FAIL held_busy_release edge=%0d got=%b expected=1", e, busy); end
            end
            if (e == 56) begin
                tests++;
                if (busy !== 1'b0) begin fails++; $display("FAIL held_idle edge=%0d got=%b expected=0", e, busy); end
            end
        end
        mdl[0] = 8'hA7;
        tests++;
        if (strobe_cnt - s0 !== 1) begin fails++; $display("FAIL held_strobe_count got=%0d expected=1", strobe_cnt - s0); end
        read_bank(2'd0, v);
        tests++;
        if (v !== 8'hA7) begin fails++; $display("FAIL held_bankA got=%h expected=a7", v); end
    endtask

    task automatic test_sel_change();
        logic [7:0] v;
        wait_idle("selchg");
        sw_data = 8'hC3;
        for (int e = 1; e <= 24; e++) begin
            btn = (e <= 12);
            sel = (e == D + 4) ? 2'd3 : 2'd0;
            tick();
        end
        mdl[3] = 8'hC3;
        read_bank(2'd3, v);
        tests++;
        if (v !== 8'hC3) begin fails++; $display("FAIL selchg_bankD got=%h expected=c3", v); end
        read_bank(2'd0, v);
        tests++;
        if (v !== mdl[0]) begin fails++; $display("FAIL selchg_bankA got=%h expected=%h", v, mdl[0]); end
    endtask

    task automatic test_reset_mid_press();
        int s0;
        logic [7:0] v;
        wait_idle("rstmid");
        sel = 2'd0;
        sw_data = 8'h3C;
        tick();
        tick();
        s0 = strobe_cnt;
        btn = 1'b1;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        tests++;
        if (led !== 8'h00) begin fails++; $display("FAIL rstmid_led got=%h expected=00", led); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got=%b expected=0", busy); end
        tests++;
        if (write_strobe !== 1'b0) begin fails++; $display("FAIL rstmid_strobe got=%b expected=0", write_strobe); end
        for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
        btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) tick();
        tests++;
        if (strobe_cnt - s0 !== 0) begin fails++; $display("FAIL rstmid_no_write got=%0d expected=0", strobe_cnt - s0); end
        read_bank(2'd0, v);
        tests++;
        if (v !== 8'h00) begin fails++; $display("FAIL rstmid_bankA_cleared got=%h expected=00", v); end
        s0 = strobe_cnt;
        btn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == D + 3) begin
                tests++;
                if (write_strobe !== 1'b1) begin fails++; $display("FAIL rstmid_fresh_strobe got=%b expected=1", write_strobe); end
            end
        end
        btn = 1'b0;
        repeat (12) tick();
        mdl[0] = 8'h3C;
        tests++;
        if (strobe_cnt - s0 !== 1) begin fails++; $display("FAIL rstmid_fresh_count got=%0d expected=1", strobe_cnt - s0); end
        read_bank(2'd0, v);
        tests++;
        if (v !== 8'h3C) begin fails++; $display("FAIL rstmid_fresh_bankA got=%h expected=3c", v); end
    endtask

    // A press written from IDLE commits iff the button is seen high for at
    // least D+1 consecutive edges; the committed sel/data are those present
    // at edge D+4 counted from the first edge that samples the button high.
    task automatic test_random();
        int s0, n, exp_w;
        logic [1:0] ws;
        logic [7:0] wd, v;
        for (int t = 0; t < 24; t++) begin
            wait_idle("rand");
            n = $urandom_range(1, 10);
            exp_w = (n >= D + 1) ? 1 : 0;
            s0 = strobe_cnt;
            ws = 2'd0;
            wd = 8'h00;
            for (int e = 1; e <= n + 14; e++) begin
                btn = (e <= n);
                sel = 2'($urandom_range(0, 3));
                sw_data = 8'($urandom_range(0, 255));
                if (e == D + 4) begin
                    ws = sel;
                    wd = sw_data;
                end
                tick();
            end
            if (exp_w == 1) mdl[ws] = wd;
            tests++;
            if (strobe_cnt - s0 !== exp_w) begin
                fails++;
                $display("FAIL rand_trial%0d_strobes len=%0d got=%0d expected=%0d", t, n, strobe_cnt - s0, exp_w);
            end
        end
        for (int b = 0; b < 4; b++) begin
            read_bank(2'(b), v);
            tests++;
            if (v !== mdl[b]) begin fails++; $display("FAIL rand_bank%0d got=%h expected=%h", b, v, mdl[b]); end
        end
    endtask

    task automatic test_auto_scan();
        logic [1:0] start, prev_idx, exp_idx;
        int n;
        press(2'd0, 8'h11);
        press(2'd1, 8'h22);
        press(2'd2, 8'h33);
        press(2'd3, 8'h44);
        prev_idx = bank_idx;
        n = 0;
        while (bank_idx === prev_idx && n < 2 * S) begin
            tick();
            n++;
        end
        tests++;
        if (bank_idx === prev_idx) begin fails++; $display("FAIL scan_no_advance got=%0d", bank_idx); end
        start = bank_idx;
        prev_idx = bank_idx;
        for (int k = 0; k < 5 * S; k++) begin
            exp_idx = 2'((int'(start) + k / S) % 4);
            tests++;
            if (bank_idx !== exp_idx) begin fails++; $display("FAIL scan_idx k=%0d got=%0d expected=%0d", k, bank_idx, exp_idx); end
            if (k > 0) begin
                tests++;
                if (led !== mdl[prev_idx]) begin fails++; $display("FAIL scan_led k=%0d got=%h expected=%h", k, led, mdl[prev_idx]); end
            end
            prev_idx = exp_idx;
            tick();
        end
    endtask

    initial begin
        test_reset();
`ifdef AUTO_SCAN_EN
        test_auto_scan();
`else
        test_initial_banks();
        test_bank_idx_latency();
        test_clean_press();
        test_glitch();
        test_held_bounce();
        test_sel_change();
        test_reset_mid_press();
        test_random();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
